// File: rtl/oem_frame_writer.sv
// rtl/oem_frame_writer.sv - serial pixel deserialiser with checkerboard odd/even bank writes
//
// Collects an MSB-first bit stream into DATA_W-bit pixels of an IMG_W x IMG_H
// frame and writes each pixel into one of NUM_BANKS odd/even bank pairs.
// A source stall of GAP_CYC cycles zero-fills the rest of the frame.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   so_data      serial data bit, MSB of each pixel first
//   so_valid     so_data qualifier
//   oem_dataout  pixel write data (held between writes)
//   oem_addr     word address inside the selected bank (held between writes)
//   odd_wr       one-hot odd-bank write strobe
//   even_wr      one-hot even-bank write strobe
//   oem_finish   one-cycle frame-complete pulse
module oem_frame_writer #(
  parameter int DATA_W    = 8,
  parameter int IMG_W     = 16,
  parameter int IMG_H     = 16,
  parameter int NUM_BANKS = 4,
  parameter int GAP_CYC   = 4,
  parameter int ADDR_W    = $clog2(IMG_W * IMG_H / (2 * NUM_BANKS))
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 so_data,
  input  logic                 so_valid,
  output logic [DATA_W-1:0]    oem_dataout,
  output logic [ADDR_W-1:0]    oem_addr,
  output logic [NUM_BANKS-1:0] odd_wr,
  output logic [NUM_BANKS-1:0] even_wr,
  output logic                 oem_finish
);

  localparam int NPIX  = IMG_W * IMG_H;
  localparam int SPAN  = NPIX / NUM_BANKS;
  localparam int PIX_W = $clog2(NPIX);
  localparam int BIT_W = $clog2(DATA_W + 1);
  localparam int GAP_W = $clog2(GAP_CYC + 1);

  // LAST_WR is the cycle the final strobe is on the outputs; FINISH follows it.
  typedef enum logic [2:0] {IDLE, SHIFT, FILL, LAST_WR, FINISH} state_t;

  state_t                 state_q, state_d;
  logic [DATA_W-1:0]      shift_q, shift_d;
  logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [BIT_W-1:0]       fill_cnt_q, fill_cnt_d;
  logic [GAP_W-1:0]       gap_q, gap_d;
  logic [PIX_W-1:0]       pix_q, pix_d;
  logic [DATA_W-1:0]      dataout_q, dataout_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [NUM_BANKS-1:0]   odd_wr_q, odd_wr_d;
  logic [NUM_BANKS-1:0]   even_wr_q, even_wr_d;
  logic                   finish_q, finish_d;

  logic                   wr_en;
  logic [DATA_W-1:0]      wr_data;
  logic [DATA_W-1:0]      shifted;

  // Frame geometry of the pixel currently being assembled.
  logic [31:0]            p_ext, row, col, bank, offs;
  logic                   odd_px;
  logic [NUM_BANKS-1:0]   bank_oh;

  assign p_ext   = 32'(pix_q);
  assign row     = p_ext / IMG_W;
  assign col     = p_ext % IMG_W;
  assign bank    = p_ext / SPAN;
  assign offs    = p_ext % SPAN;
  assign odd_px  = 1'((row + col) & 32'd1);
  assign bank_oh = NUM_BANKS'(1) << bank;
  assign shifted = {shift_q[DATA_W-2:0], so_data};

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    fill_cnt_d = fill_cnt_q;
    gap_d      = gap_q;
    pix_d      = pix_q;
    dataout_d  = dataout_q;
    addr_d     = addr_q;
    odd_wr_d   = '0;
    even_wr_d  = '0;
    finish_d   = 1'b0;
    wr_en      = 1'b0;
    wr_data    = '0;

    case (state_q)
      // FINISH doubles as IDLE so a bit arriving there starts the next frame.
      IDLE, FINISH: begin
        if (state_q == FINISH) state_d = IDLE;
        if (so_valid) begin
          shift_d   = shifted;
          bit_cnt_d = BIT_W'(1);
          gap_d     = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (so_valid) begin
          gap_d   = '0;
          shift_d = shifted;
          if (bit_cnt_q == BIT_W'(DATA_W - 1)) begin
            bit_cnt_d = '0;
            wr_en     = 1'b1;
            wr_data   = shifted;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end else if (gap_q == GAP_W'(GAP_CYC - 1)) begin
          // Source has stalled: drop the partial pixel and pad the frame.
          state_d    = FILL;
          shift_d    = '0;
          bit_cnt_d  = '0;
          fill_cnt_d = '0;
          gap_d      = '0;
        end else if (gap_q != GAP_W'(GAP_CYC)) begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      FILL: begin
        // One zero pixel per DATA_W cycles, mimicking the serial pixel rate.
        if (fill_cnt_q == BIT_W'(DATA_W - 1)) begin
          fill_cnt_d = '0;
          wr_en      = 1'b1;
        end else begin
          fill_cnt_d = fill_cnt_q + BIT_W'(1);
        end
      end
      LAST_WR: begin
        state_d  = FINISH;
        finish_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (wr_en) begin
      odd_wr_d  = odd_px ? bank_oh : '0;
      even_wr_d = odd_px ? '0 : bank_oh;
      addr_d    = ADDR_W'(offs >> 1);
      dataout_d = wr_data;
      if (pix_q == PIX_W'(NPIX - 1)) begin
        pix_d   = '0;
        state_d = LAST_WR;
      end else begin
        pix_d = pix_q + PIX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      fill_cnt_q <= '0;
      gap_q      <= '0;
      pix_q      <= '0;
      dataout_q  <= '0;
      addr_q     <= '0;
      odd_wr_q   <= '0;
      even_wr_q  <= '0;
      finish_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      fill_cnt_q <= fill_cnt_d;
      gap_q      <= gap_d;
      pix_q      <= pix_d;
      dataout_q  <= dataout_d;
      addr_q     <= addr_d;
      odd_wr_q   <= odd_wr_d;
      even_wr_q  <= even_wr_d;
      finish_q   <= finish_d;
    end
  end

  assign oem_dataout = dataout_q;
  assign oem_addr    = addr_q;
  assign odd_wr      = odd_wr_q;
  assign even_wr     = even_wr_q;
  assign oem_finish  = finish_q;

endmodule

// File: tb/tb_oem_frame_writer.sv
// tb/tb_oem_frame_writer.sv - scoreboard bench for oem_frame_writer (default and small configs)
module tb_oem_frame_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic        so_data;
  logic        so_valid;

  logic [7:0]  data1;
  logic [4:0]  addr1;
  logic [3:0]  odd_wr1, even_wr1;
  logic        oem_finish1;

  logic [11:0] data2;
  logic [2:0]  addr2;
  logic [1:0]  odd_wr2, even_wr2;
  logic        oem_finish2;

  oem_frame_writer dut1 (
    .clk(clk), .reset(reset), .so_data(so_data), .so_valid(so_valid),
    .oem_dataout(data1), .oem_addr(addr1), .odd_wr(odd_wr1), .even_wr(even_wr1),
    .oem_finish(oem_finish1)
  );

  oem_frame_writer #(.DATA_W(12), .IMG_W(8), .IMG_H(4), .NUM_BANKS(2)) dut2 (
    .clk(clk), .reset(reset), .so_data(so_data), .so_valid(so_valid),
    .oem_dataout(data2), .oem_addr(addr2), .odd_wr(odd_wr2), .even_wr(even_wr2),
    .oem_finish(oem_finish2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int p;
    int data;
    int cyc;
  } wr_t;

  wr_t q1[$];
  wr_t q2[$];
  int  fin1[$];
  int  fin2[$];
  int  fin_seen[$];
  int  total = 0;
  int  bad = 0;
  int  writes2 = 0;
  bit  en1 = 1'b0;
  bit  en2 = 1'b0;
  wr_t e1, e2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, want);
    end
  endtask

  task automatic check_wr(input string pre, input wr_t e, input int w, input int span,
                          input logic [31:0] odd_o, input logic [31:0] even_o,
                          input logic [31:0] addr_o, input logic [31:0] data_o);
    int          odd_px;
    logic [31:0] oh;
    odd_px = ((e.p / w) + (e.p % w)) % 2;
    oh     = 32'd1 << (e.p / span);
    chk({pre, "_odd"},   odd_o,  (odd_px != 0) ? oh : 32'd0);
    chk({pre, "_even"},  even_o, (odd_px != 0) ? 32'd0 : oh);
    chk({pre, "_addr"},  addr_o, 32'((e.p % span) / 2));
    chk({pre, "_data"},  data_o, 32'(e.data));
    chk({pre, "_cycle"}, 32'(cyc), 32'(e.cyc));
  endtask

  // Monitors sample on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    if (en1 && reset) begin
      if ((odd_wr1 | even_wr1) != 4'd0) begin
        if (q1.size() == 0) chk("wr1_unexpected", 32'(odd_wr1 | even_wr1), 32'd0);
        else begin
          e1 = q1.pop_front();
          check_wr("wr1", e1, 16, 64, 32'(odd_wr1), 32'(even_wr1), 32'(addr1), 32'(data1));
          case (e1.p)
            0:   chk("p0_even0",    32'(even_wr1), 32'd1);
            1:   chk("p1_odd0",     32'(odd_wr1),  32'd1);
            16:  chk("p16_addr8",   32'(addr1),    32'd8);
            64:  chk("p64_even1",   32'(even_wr1), 32'd2);
            255: chk("p255_addr31", 32'(addr1),    32'd31);
            default: ;
          endcase
        end
      end
      if (oem_finish1) begin
        fin_seen.push_back(cyc);
        if (fin1.size() == 0) chk("fin1_unexpected", 32'(oem_finish1), 32'd0);
        else chk("fin1_cycle", 32'(cyc), 32'(fin1.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (en2 && reset) begin
      if ((odd_wr2 | even_wr2) != 2'd0) begin
        writes2++;
        if (q2.size() == 0) chk("wr2_unexpected", 32'(odd_wr2 | even_wr2), 32'd0);
        else begin
          e2 = q2.pop_front();
          check_wr("wr2", e2, 8, 16, 32'(odd_wr2), 32'(even_wr2), 32'(addr2), 32'(data2));
          if (e2.p == 16) begin
            chk("cfg2_p16_even1", 32'(even_wr2), 32'd2);
            chk("cfg2_p16_addr0", 32'(addr2),    32'd0);
          end
        end
      end
      if (oem_finish2) begin
        chk("cfg2_write_count", 32'(writes2), 32'd32);
        writes2 = 0;
        if (fin2.size() == 0) chk("fin2_unexpected", 32'(oem_finish2), 32'd0);
        else chk("fin2_cycle", 32'(cyc), 32'(fin2.pop_front()));
      end
    end
  end

  task automatic push(input int which, input int p, input int data, input int c);
    wr_t e;
    e.p = p; e.data = data; e.cyc = c;
    if (which == 1) begin
      q1.push_back(e);
      if (p == 255) fin1.push_back(c + 1);
    end else begin
      q2.push_back(e);
      if (p == 31) fin2.push_back(c + 1);
    end
  endtask

  task automatic bit_(input logic b);
    @(negedge clk);
    so_valid = 1'b1;
    so_data  = b;
  endtask

  task automatic idle_(input int n);
    repeat (n) begin
      @(negedge clk);
      so_valid = 1'b0;
      so_data  = 1'($urandom);
    end
  endtask

  // A positive gap inserts that many invalid cycles after the 4th bit.
  task automatic send_pixel(input int which, input int nb, input int p,
                            input logic [31:0] data, input int gap);
    for (int i = nb - 1; i >= 0; i--) begin
      if (gap > 0 && i == nb - 5) idle_(gap);
      bit_(data[i]);
    end
    push(which, p, int'(data), cyc + 1);
  endtask

  task automatic send_frame(input int which, input int nb, input int first, input int last,
                            input int mul, input int add, input int mask, input int gap_pix);
    for (int p = first; p <= last; p++)
      send_pixel(which, nb, p, (p * mul + add) & mask, (p == gap_pix) ? 3 : 0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    idle_(1);
    while ((q1.size() + q2.size() + fin1.size() + fin2.size()) != 0 && n < 3000) begin
      idle_(1);
      n++;
    end
    chk("drain_pending", 32'(q1.size() + q2.size() + fin1.size() + fin2.size()), 32'd0);
    idle_(3);
  endtask

  initial begin
    int c0;
    so_valid = 1'b0;
    so_data  = 1'b0;
    reset    = 1'b1;
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_data",   32'(data1),       32'd0);
    chk("rst_addr",   32'(addr1),       32'd0);
    chk("rst_odd",    32'(odd_wr1),     32'd0);
    chk("rst_even",   32'(even_wr1),    32'd0);
    chk("rst_finish", 32'(oem_finish1), 32'd0);
    reset = 1'b1;
    en1   = 1'b1;
    idle_(3);

    // Frame A continuous, frame B's first bit lands in A's FINISH cycle.
    send_frame(1, 8, 0, 255, 1, 1, 255, -1);
    idle_(1);
    send_frame(1, 8, 0, 255, 7, 90, 255, -1);
    drain();
    chk("finish_spacing", 32'(fin_seen[1] - fin_seen[0]), 32'd2049);

    // Short stall inside pixel 10 must be tolerated.
    send_frame(1, 8, 0, 255, 3, 11, 255, 10);
    drain();

    // Stall after pixel 99 plus 3 bits -> zero-fill, so_valid toggles ignored.
    send_frame(1, 8, 0, 99, 5, 2, 255, -1);
    for (int i = 0; i < 3; i++) bit_(1'b1);
    c0 = cyc;
    for (int p = 100; p <= 255; p++) push(1, p, 0, c0 + 13 + 8 * (p - 100));
    idle_(4);
    repeat (1240) begin
      @(negedge clk);
      so_valid = 1'($urandom);
      so_data  = 1'($urandom);
    end
    idle_(30);
    drain();

    // Reset in the middle of pixel 37, then a clean frame from p0.
    send_frame(1, 8, 0, 36, 5, 3, 255, -1);
    for (int i = 0; i < 4; i++) bit_(1'b1);
    idle_(2);
    chk("pre_reset_queue", 32'(q1.size()), 32'd0);
    @(negedge clk);
    so_valid = 1'b0;
    reset    = 1'b0;
    #1;
    chk("midrst_data",   32'(data1),              32'd0);
    chk("midrst_addr",   32'(addr1),              32'd0);
    chk("midrst_strobe", 32'(odd_wr1 | even_wr1), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    idle_(2);
    send_frame(1, 8, 0, 255, 9, 4, 255, -1);
    drain();

    // Small configuration on the second instance.
    en1 = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset   = 1'b1;
    writes2 = 0;
    en2     = 1'b1;
    idle_(2);
    send_frame(2, 12, 0, 31, 100, 7, 'hFFF, -1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/oem_frame_writer.md
Name: oem_frame_writer

Overview:
- Parametrised successor to the serial odd/even memory loader.
- Deserialises an MSB-first bit stream into DATA_W-bit pixels of an IMG_W x IMG_H frame.
- Distributes pixels in checkerboard fashion over NUM_BANKS odd/even bank pairs.
- Zero-fills the rest of the frame when the source stalls, then pulses oem_finish. Sits between the serial source and the on-chip frame memories.

Parameters:
DATA_W, 8, bits per pixel
IMG_W, 16, pixels per row (must be even)
IMG_H, 16, rows per frame
NUM_BANKS, 4, odd/even bank pairs; IMG_W*IMG_H divisible by 2*NUM_BANKS
GAP_CYC, 4, consecutive so_valid-low cycles that trigger zero-fill
ADDR_W, clog2(IMG_W*IMG_H/(2*NUM_BANKS)), bank address width (derived)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous active-low reset
so_data  in  1  serial data bit, MSB of each pixel first
so_valid  in  1  so_data is valid this cycle
oem_dataout  out  DATA_W  pixel write data
oem_addr  out  ADDR_W  write address within selected bank
odd_wr  out  NUM_BANKS  one-hot odd-bank write strobe
even_wr  out  NUM_BANKS  one-hot even-bank write strobe
oem_finish  out  1  one-cycle frame-complete pulse

Behaviour:
- Reset (reset=0, async): all outputs 0, state IDLE, counters and shift register cleared. Reset mid-frame discards the frame; there is no resume.
- Pixel index p = row*IMG_W + col, counted 0..IMG_W*IMG_H-1.
- SPAN = IMG_W*IMG_H/NUM_BANKS.
- Bank b = p / SPAN.
- Address = (p mod SPAN) >> 1.
- Even bank when (row+col) is even, odd bank otherwise.
- States:
  - IDLE: wait for so_valid=1; that cycle's bit is captured as bit 0 of pixel 0. Go to SHIFT.
  - SHIFT: a bit is shifted in on every so_valid=1 cycle. On the DATA_W-th bit, register the write.
    - Next cycle: exactly one of odd_wr[b]/even_wr[b] is high for 1 cycle, with oem_dataout/oem_addr valid (write latency 1 cycle).
    - The gap counter counts consecutive so_valid=0 cycles and clears on so_valid=1.
    - A gap shorter than GAP_CYC is tolerated; partial pixel bits are retained.
    - Gap reaching GAP_CYC: discard partial bits, go to FILL.
  - FILL: so_valid and so_data are ignored. Write one zero pixel every DATA_W cycles, at next p; the first zero write comes DATA_W cycles after entering FILL.
  - FINISH: entered the cycle after the last pixel's strobe. oem_finish=1 for one cycle, all strobes 0, then IDLE.
- Back-to-back frames: a so_valid=1 bit in the FINISH cycle is captured as bit 0 of the next frame.
- Strobes are 0 in every cycle without a write. oem_dataout/oem_addr hold their last value between writes.
- Gap counter saturates; it is inactive in IDLE (idle between frames never triggers FILL).
- Last pixel written in SHIFT with so_valid dropping simultaneously: FINISH, no FILL.
- Counters wrap to 0 at frame end; p never exceeds IMG_W*IMG_H-1.

Test Plan:
- Defaults; reset; continuous 2048 bits, pixel p = (p+1) mod 256 -> required writes:
  - p0: even_wr[0], addr 0, data 0x01, cycle after bit 8.
  - p1: odd_wr[0], addr 0.
  - p16: odd_wr[0], addr 8.
  - p64: even_wr[1], addr 0.
  - p255: even_wr[3], addr 31.
  - oem_finish exactly 1 cycle later, then all outputs idle.
- so_valid low for 3 cycles between bits 4 and 5 of pixel 10 -> pixel 10 data intact, written 1 cycle after its 8th valid bit, no FILL.
- Stream stops after pixel 99 plus 3 bits, so_valid low 4 cycles -> FILL:
  - Pixels 100..255 written as 0x00, spaced 8 cycles; first at 8 cycles after FILL entry.
  - Toggling so_valid during FILL has no effect; oem_finish after pixel 255.
- reset pulsed low mid-pixel-37 -> outputs 0 immediately. Next frame restarts at p0 / even_wr[0] / addr 0.
- Two frames back-to-back, second's first bit in FINISH cycle -> second frame's p0 data correct; two oem_finish pulses, 2049 cycles apart.
- DATA_W=12, IMG_W=8, IMG_H=4, NUM_BANKS=2 -> ADDR_W=3; p16 goes to even_wr[1] addr 0; oem_finish after 32 writes.
